// File: rtl/ysyx_22050550_if_id_skid_pkg.sv
// Shared constants for the IF->ID skid boundary: widths, reset/bubble values, occupancy codes.
package ysyx_22050550_if_id_skid_pkg;

  localparam int unsigned IF_ID_PC_W     = 64;
  localparam int unsigned IF_ID_INST_W   = 32;
  localparam logic [63:0] IF_ID_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] IF_ID_NOP_INST = 32'h0000_0013;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  // A skid entry without a main entry cannot arise; it is folded into TWO.
  function automatic logic [1:0] occ_of(input logic main_v, input logic skid_v);
    if (skid_v) return OCC_TWO;
    else if (main_v) return OCC_ONE;
    else return OCC_EMPTY;
  endfunction

endpackage

// File: rtl/ysyx_22050550_skid_slot.sv
// One held entry of the IF->ID boundary: a valid bit plus {pc,inst}, with load and clear.
module ysyx_22050550_skid_slot #(
  parameter int unsigned         PC_W     = 64,
  parameter int unsigned         INST_W   = 32,
  parameter logic [PC_W-1:0]     RST_PC   = '0,
  parameter logic [INST_W-1:0]   RST_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [INST_W-1:0] d_inst,
  output logic              valid,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] inst
);

  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;

  // Clearing drops only the valid bit; the payload is kept so out_pc holds its last value.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (load) begin
      valid_d = 1'b1;
      pc_d    = d_pc;
      inst_d  = d_inst;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= RST_PC;
      inst_q  <= RST_INST;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign inst  = inst_q;

endmodule

// File: rtl/ysyx_22050550_if_id_skid.sv
// IF->ID pipeline boundary with a two-entry (main + skid) buffer so in_ready is registered.
// Optional counters enabled by macro YSYX_22050550_IF_ID_PERF_EN.
module ysyx_22050550_if_id_skid
  import ysyx_22050550_if_id_skid_pkg::*;
#(
  parameter int unsigned       PC_W     = IF_ID_PC_W,
  parameter int unsigned       INST_W   = IF_ID_INST_W,
  parameter logic [PC_W-1:0]   RESET_PC = IF_ID_RESET_PC[PC_W-1:0],
  parameter logic [INST_W-1:0] NOP_INST = IF_ID_NOP_INST[INST_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst
`ifdef YSYX_22050550_IF_ID_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  logic              main_v, skid_v;
  logic [PC_W-1:0]   main_pc, skid_pc;
  logic [INST_W-1:0] main_inst, skid_inst;

  logic              main_load, main_clear, skid_load, skid_clear;
  logic [PC_W-1:0]   main_d_pc;
  logic [INST_W-1:0] main_d_inst;
  logic              acc, drn;
  logic [1:0]        occ;

  assign in_ready = ~skid_v;
  assign acc      = in_valid & in_ready;
  assign drn      = main_v & out_ready;
  assign occ      = occ_of(main_v, skid_v);

  always_comb begin
    main_load   = 1'b0;
    main_clear  = 1'b0;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    main_d_pc   = in_pc;
    main_d_inst = in_inst;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (occ)
        OCC_EMPTY: main_load = acc;
        OCC_ONE: begin
          if (acc && drn)  main_load  = 1'b1;
          else if (acc)    skid_load  = 1'b1;
          else if (drn)    main_clear = 1'b1;
        end
        OCC_TWO: begin
          // in_ready is low here, so the only event is a drain that promotes skid to main.
          if (drn) begin
            main_load   = 1'b1;
            main_d_pc   = skid_pc;
            main_d_inst = skid_inst;
            skid_clear  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  ysyx_22050550_skid_slot #(
    .PC_W(PC_W), .INST_W(INST_W), .RST_PC(RESET_PC), .RST_INST(NOP_INST)
  ) u_main (
    .clk(clk), .rst(rst), .load(main_load), .clear(main_clear),
    .d_pc(main_d_pc), .d_inst(main_d_inst),
    .valid(main_v), .pc(main_pc), .inst(main_inst)
  );

  ysyx_22050550_skid_slot #(
    .PC_W(PC_W), .INST_W(INST_W), .RST_PC(RESET_PC), .RST_INST(NOP_INST)
  ) u_skid (
    .clk(clk), .rst(rst), .load(skid_load), .clear(skid_clear),
    .d_pc(in_pc), .d_inst(in_inst),
    .valid(skid_v), .pc(skid_pc), .inst(skid_inst)
  );

  assign out_valid = main_v;
  assign out_pc    = main_pc;
  assign out_inst  = main_v ? main_inst : NOP_INST;

`ifdef YSYX_22050550_IF_ID_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // A main entry drained in the flush cycle is delivered, so it is not counted as discarded.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_v && !out_ready)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush)
      flush_cnt_d = flush_cnt_q + {31'd0, main_v & ~drn} + {31'd0, skid_v};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
